// File: rtl/bus_timer_mailbox.sv
// Memory-mapped CPU bus responder: 32-bit compare timer with interrupt, a scratch
// register and a transmit mailbox FIFO drained over a valid/ready port.
`timescale 1ns/1ps
module bus_timer_mailbox #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        irq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    A_CTRL, A_COMPARE, A_COUNT, A_STATUS, A_FIFO, A_SCRATCH, A_RSV6, A_RSV7
  } reg_addr_e;

  logic             r_en, r_autoreload, r_irq_en;
  logic [CNT_W-1:0] r_compare, r_count;
  logic             r_match, r_overflow, r_irq;
  logic [31:0]      r_scratch;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_fifo_cnt;
  logic [31:0]      r_out_data;

  reg_addr_e        w_sel;
  logic             w_wr, w_hit, w_full, w_empty, w_pop, w_push_ok, w_set_ovf;
  logic             w_wr_fifo, w_wr_stat;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic             w_unused;

  // Only addr[4:2] selects a register; the remaining address bits are don't-care.
  assign w_unused  = &{1'b0, addr[31:5], addr[1:0]};

  assign w_sel     = reg_addr_e'(addr[4:2]);
  assign w_wr      = cs & wr_rd;
  assign w_wr_fifo = w_wr && (w_sel == A_FIFO);
  assign w_wr_stat = w_wr && (w_sel == A_STATUS);
  assign w_hit     = r_en && (r_count == r_compare);

  assign w_empty   = (r_fifo_cnt == '0);
  assign w_full    = (r_fifo_cnt == DEPTH_C);
  assign w_pop     = !w_empty && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push_ok = w_wr_fifo && (!w_full || w_pop);
  assign w_set_ovf = w_wr_fifo && w_full && !w_pop;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  assign irq       = r_irq;
  assign out_valid = !w_empty;
  assign out_data  = r_out_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en         <= 1'b0;
      r_autoreload <= 1'b0;
      r_irq_en     <= 1'b0;
      r_compare    <= '1;
      r_count      <= '0;
      r_match      <= 1'b0;
      r_overflow   <= 1'b0;
      r_irq        <= 1'b0;
      r_scratch    <= '0;
    end else begin
      if (w_wr && w_sel == A_CTRL)
        {r_irq_en, r_autoreload, r_en} <= data_bus_write[2:0];
      if (w_wr && w_sel == A_COMPARE)
        r_compare <= data_bus_write[CNT_W-1:0];
      if (w_wr && w_sel == A_SCRATCH)
        r_scratch <= data_bus_write;

      if (w_wr && w_sel == A_COUNT)
        r_count <= data_bus_write[CNT_W-1:0];
      else if (r_en)
        r_count <= (w_hit && r_autoreload) ? '0 : r_count + 1'b1;

      // Hardware set beats a same-cycle write-one-to-clear.
      if (w_hit)
        r_match <= 1'b1;
      else if (w_wr_stat && data_bus_write[0])
        r_match <= 1'b0;
      if (w_set_ovf)
        r_overflow <= 1'b1;
      else if (w_wr_stat && data_bus_write[1])
        r_overflow <= 1'b0;

      r_irq <= r_match & r_irq_en;
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= data_bus_write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_out_data <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push_ok, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      // Forward the incoming word when it lands in the slot that becomes the head.
      if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt))
        r_out_data <= data_bus_write;
      else
        r_out_data <= r_mem[w_rd_ptr_nxt];
    end
  end

  // NOTE: defaulting the output first keeps this combinational block latch-free.
  always_comb begin
    data_bus_read = '0;
    if (cs && !wr_rd) begin
      case (w_sel)
        A_CTRL:    data_bus_read[2:0] = {r_irq_en, r_autoreload, r_en};
        A_COMPARE: data_bus_read[CNT_W-1:0] = r_compare;
        A_COUNT:   data_bus_read[CNT_W-1:0] = r_count;
        A_STATUS: begin
          data_bus_read[0]           = r_match;
          data_bus_read[1]           = r_overflow;
          data_bus_read[2]           = w_full;
          data_bus_read[3]           = w_empty;
          data_bus_read[8 +: PTR_W+1] = r_fifo_cnt;
        end
        A_SCRATCH: data_bus_read = r_scratch;
        default:   data_bus_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer_mailbox.sv
// Directed self-checking bench for bus_timer_mailbox: register map, timer,
// interrupt timing, mailbox FIFO and asynchronous reset.
`timescale 1ns/1ps
module tb_bus_timer_mailbox;

  localparam logic [31:0] A_CTRL = 32'h00, A_CMP = 32'h04, A_CNT = 32'h08, A_STAT = 32'h0C;
  localparam logic [31:0] A_FIFO = 32'h10, A_SCR = 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        irq;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  logic        rd_irq;

  bus_timer_mailbox #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .cs(cs), .wr_rd(wr_rd),
    .data_bus_write(data_bus_write), .data_bus_read(data_bus_read), .irq(irq),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d;
    @(posedge clk); #1;
    cs = 1'b0; wr_rd = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b0; addr = a;
    #1 d = data_bus_read; rd_irq = irq;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [8] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0; out_ready = 1'b0;
    #12;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_rd(32'(i * 4), rd);
      n_tests++;
      if (rd !== exp_rst[i]) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", i, rd, exp_rst[i]); end
    end
  endtask

  task automatic test_bus_rules();
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b1; addr = A_SCR; data_bus_write = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (data_bus_read !== 32'h0) begin n_fail++; $display("FAIL rd_during_wr: got %h expected 0", data_bus_read); end
    @(posedge clk); #1;
    cs = 1'b0; wr_rd = 1'b0;
    #1;
    n_tests++; if (data_bus_read !== 32'h0) begin n_fail++; $display("FAIL rd_cs_low: got %h expected 0", data_bus_read); end
    bus_rd(A_SCR, rd);
    n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL scratch: got %h expected deadbeef", rd); end
    bus_wr(A_CTRL, 32'hFFFF_FFF8);
    bus_rd(A_CTRL, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ctrl_mask: got %h expected 0", rd); end
  endtask

  task automatic test_timer();
    logic [31:0] exp_cnt [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    logic        exp_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus_wr(A_CMP, 32'd3);
    bus_wr(A_CTRL, 32'h7);
    for (int i = 0; i < 6; i++) begin
      bus_rd(A_CNT, rd);
      n_tests++; if (rd !== exp_cnt[i]) begin n_fail++; $display("FAIL auto_cnt%0d: got %h expected %h", i, rd, exp_cnt[i]); end
      n_tests++; if (rd_irq !== exp_irq[i]) begin n_fail++; $display("FAIL auto_irq%0d: got %b expected %b", i, rd_irq, exp_irq[i]); end
    end
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h9) begin n_fail++; $display("FAIL auto_match: got %h expected 9", rd); end
    bus_wr(A_CTRL, 32'h4);
    bus_wr(A_STAT, 32'h1);
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h8) begin n_fail++; $display("FAIL w1c_match: got %h expected 8", rd); end
    n_tests++; if (rd_irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag: got %b expected 1", rd_irq); end
    bus_rd(A_CNT, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cnt_hold: got %h expected 0", rd); end
    n_tests++; if (rd_irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b expected 0", rd_irq); end

    bus_wr(A_CNT, 32'd0);
    bus_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      bus_rd(A_CNT, rd);
      n_tests++; if (rd !== 32'(i)) begin n_fail++; $display("FAIL noauto_cnt%0d: got %h expected %h", i, rd, i); end
    end
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h9) begin n_fail++; $display("FAIL noauto_match: got %h expected 9", rd); end
    n_tests++; if (rd_irq !== 1'b0) begin n_fail++; $display("FAIL noauto_irq: got %b expected 0", rd_irq); end
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_STAT, 32'h1);
  endtask

  task automatic test_priority();
    logic [31:0] exp_wrap [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    bus_wr(A_CTRL, 32'h1);
    bus_wr(A_CNT, 32'h10);
    bus_rd(A_CNT, rd);
    n_tests++; if (rd !== 32'h10) begin n_fail++; $display("FAIL cnt_load: got %h expected 10", rd); end
    bus_rd(A_CNT, rd);
    n_tests++; if (rd !== 32'h11) begin n_fail++; $display("FAIL cnt_after_load: got %h expected 11", rd); end

    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_CNT, 32'hFFFF_FFFE);
    bus_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus_rd(A_CNT, rd);
      n_tests++; if (rd !== exp_wrap[i]) begin n_fail++; $display("FAIL wrap%0d: got %h expected %h", i, rd, exp_wrap[i]); end
    end
    bus_wr(A_CTRL, 32'h0);

    bus_wr(A_STAT, 32'h3);
    bus_wr(A_CMP, 32'd5);
    bus_wr(A_CNT, 32'd3);
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_CNT, rd);
    n_tests++; if (rd !== 32'd3) begin n_fail++; $display("FAIL pri_cnt3: got %h expected 3", rd); end
    bus_rd(A_CNT, rd);
    n_tests++; if (rd !== 32'd4) begin n_fail++; $display("FAIL pri_cnt4: got %h expected 4", rd); end
    bus_wr(A_STAT, 32'h1);
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h9) begin n_fail++; $display("FAIL set_wins: got %h expected 9", rd); end
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_STAT, 32'h1);
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h8) begin n_fail++; $display("FAIL pri_clear: got %h expected 8", rd); end
  endtask

  task automatic test_fifo_fill_drain();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_idle_valid: got %b expected 0", out_valid); end
    bus_wr(A_FIFO, 32'hA0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data !== 32'hA0) begin n_fail++; $display("FAIL fwft_data: got %h expected a0", out_data); end
    for (int i = 1; i < 9; i++) bus_wr(A_FIFO, 32'hA0 + 32'(i));
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h806) begin n_fail++; $display("FAIL fifo_full_stat: got %h expected 806", rd); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + 32'(i)) begin
        n_fail++; $display("FAIL drain%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 32'hA0 + 32'(i));
      end
    end
    @(negedge clk); out_ready = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b expected 0", out_valid); end
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'hA) begin n_fail++; $display("FAIL drained_stat: got %h expected a", rd); end
    bus_wr(A_STAT, 32'h2);
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h8) begin n_fail++; $display("FAIL ovf_clear: got %h expected 8", rd); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) bus_wr(A_FIFO, 32'hB0 + 32'(i));
    @(negedge clk);
    out_ready = 1'b1; cs = 1'b1; wr_rd = 1'b1; addr = A_FIFO; data_bus_write = 32'hB8;
    #1;
    n_tests++; if (out_data !== 32'hB0) begin n_fail++; $display("FAIL b2b_head: got %h expected b0", out_data); end
    @(posedge clk); #1;
    out_ready = 1'b0; cs = 1'b0; wr_rd = 1'b0;
    bus_rd(A_STAT, rd);
    n_tests++; if (rd !== 32'h804) begin n_fail++; $display("FAIL b2b_stat: got %h expected 804", rd); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hB1 + 32'(i)) begin
        n_fail++; $display("FAIL b2b_drain%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 32'hB1 + 32'(i));
      end
    end
    @(negedge clk); out_ready = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    bus_wr(A_STAT, 32'h3);
    bus_wr(A_CMP, 32'd2);
    bus_wr(A_CNT, 32'd0);
    bus_wr(A_FIFO, 32'hC0);
    bus_wr(A_FIFO, 32'hC1);
    bus_wr(A_FIFO, 32'hC2);
    bus_wr(A_CTRL, 32'h5);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst_irq: got %b expected 1", irq); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hC1) begin
      n_fail++; $display("FAIL pre_rst_head: got v=%b d=%h expected v=1 d=c1", out_valid, out_data);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", out_data); end
    cs = 1'b1; wr_rd = 1'b0; addr = A_CNT;
    #1;
    n_tests++; if (data_bus_read !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", data_bus_read); end
    addr = A_STAT;
    #1;
    n_tests++; if (data_bus_read !== 32'h8) begin n_fail++; $display("FAIL rst_stat: got %h expected 8", data_bus_read); end
    cs = 1'b0;
    @(negedge clk); rst = 1'b1;
    bus_rd(A_CTRL, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 0", rd); end
    bus_rd(A_CMP, rd);
    n_tests++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp: got %h expected ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_bus_rules();
    test_timer();
    test_priority();
    test_fifo_fill_drain();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
